// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding, grant codes and watchdog read data for the Wishbone arbiter
package wb_arb_pkg;
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    localparam logic [1:0] GNT_M0 = 2'b01;
    localparam logic [1:0] GNT_M1 = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout: bus watchdog counting unacknowledged strobe cycles and holding the sticky timeout flag
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic ack,
    input  logic rel,
    input  logic err_clr,
    output logic fire,
    output logic to_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign fire = stb && cnt == CW'(TIMEOUT_CYCLES);
    always_ff @(posedge clk) begin
        cnt <= (rst || ack || !stb || rel || fire) ? '0 : cnt + 1'b1;
        to_err <= rst ? 1'b0 : fire ? 1'b1 : err_clr ? 1'b0 : to_err;
    end
endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin two-master Wishbone arbiter; define WB_ARB_TIMEOUT_EN to add the bus watchdog
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_wdat,
    input  logic [3:0]    m0_sel,
    input  logic          m0_we,
    input  logic          m0_stb,
    input  logic          m0_cyc,
    output logic [DW-1:0] m0_rdat,
    output logic          m0_ack,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_wdat,
    input  logic [3:0]    m1_sel,
    input  logic          m1_we,
    input  logic          m1_stb,
    input  logic          m1_cyc,
    output logic [DW-1:0] m1_rdat,
    output logic          m1_ack,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_wdat,
    output logic [3:0]    s_sel,
    output logic          s_we,
    output logic          s_stb,
    output logic          s_cyc,
    input  logic [DW-1:0] s_rdat,
    input  logic          s_ack,
    output logic [1:0]    gnt,
    output logic          to_err,
    input  logic          err_clr
);
    state_t state;
    logic last, sel0, sel1, stb_raw, to_fire;
    assign sel0 = state == GNT0 && !wb_rst;
    assign sel1 = state == GNT1 && !wb_rst;
    assign s_adr = sel0 ? m0_adr : sel1 ? m1_adr : '0;
    assign s_wdat = sel0 ? m0_wdat : sel1 ? m1_wdat : '0;
    assign s_sel = sel0 ? m0_sel : sel1 ? m1_sel : '0;
    assign s_we = sel0 ? m0_we : sel1 & m1_we;
    assign s_cyc = sel0 ? m0_cyc : sel1 & m1_cyc;
    assign stb_raw = sel0 ? m0_stb : sel1 & m1_stb;
    assign s_stb = stb_raw & ~to_fire;
    assign m0_ack = sel0 & (s_ack | to_fire);
    assign m1_ack = sel1 & (s_ack | to_fire);
    assign m0_rdat = !sel0 ? '0 : to_fire ? DW'(TIMEOUT_RDATA) : s_rdat;
    assign m1_rdat = !sel1 ? '0 : to_fire ? DW'(TIMEOUT_RDATA) : s_rdat;
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state <= IDLE;
            gnt <= '0;
            last <= 1'b1;
        end else if (state == IDLE ? m0_cyc && (!m1_cyc || last) : state == GNT1 && !m1_cyc && m0_cyc) begin
            state <= GNT0;
            gnt <= GNT_M0;
            last <= 1'b0;
        end else if (state == IDLE ? m1_cyc : state == GNT0 && !m0_cyc && m1_cyc) begin
            state <= GNT1;
            gnt <= GNT_M1;
            last <= 1'b1;
        end else if ((state == GNT0 && !m0_cyc) || (state == GNT1 && !m1_cyc)) begin
            state <= IDLE;
            gnt <= '0;
        end
    end
`ifdef WB_ARB_TIMEOUT_EN
    logic rel;
    assign rel = (state == GNT0 && !m0_cyc) || (state == GNT1 && !m1_cyc);
    wb_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk(wb_clk),
        .rst(wb_rst),
        .stb(stb_raw),
        .ack(s_ack),
        .rel(rel),
        .err_clr(err_clr),
        .fire(to_fire),
        .to_err(to_err)
    );
`else
    logic unused_cfg;
    assign unused_cfg = err_clr ^ (TIMEOUT_CYCLES > 0);
    assign to_fire = 1'b0;
    assign to_err = 1'b0;
`endif
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: scoreboard bench with a slave model and a rule-level grant model
module tb_wb_bus_arbiter;
    logic wb_clk, wb_rst, err_clr, to_err;
    logic [31:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat, s_adr, s_wdat, s_rdat;
    logic [3:0] m0_sel, m1_sel, s_sel;
    logic m0_we, m0_stb, m0_cyc, m0_ack, m1_we, m1_stb, m1_cyc, m1_ack;
    logic s_we, s_stb, s_cyc, s_ack;
    logic [1:0] gnt;

    wb_bus_arbiter #(.DW(32), .AW(32), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .m0_adr(m0_adr), .m0_wdat(m0_wdat), .m0_sel(m0_sel), .m0_we(m0_we),
        .m0_stb(m0_stb), .m0_cyc(m0_cyc), .m0_rdat(m0_rdat), .m0_ack(m0_ack),
        .m1_adr(m1_adr), .m1_wdat(m1_wdat), .m1_sel(m1_sel), .m1_we(m1_we),
        .m1_stb(m1_stb), .m1_cyc(m1_cyc), .m1_rdat(m1_rdat), .m1_ack(m1_ack),
        .s_adr(s_adr), .s_wdat(s_wdat), .s_sel(s_sel), .s_we(s_we),
        .s_stb(s_stb), .s_cyc(s_cyc), .s_rdat(s_rdat), .s_ack(s_ack),
        .gnt(gnt), .to_err(to_err), .err_clr(err_clr)
    );

    typedef struct packed {logic rd; logic [31:0] dat;} exp_t;
    exp_t q0[$], q1[$];
    int n_chk = 0, n_fail = 0;
    int acks0 = 0, acks1 = 0;
    int fix_dly = -1, wcnt = 0;
    logic [1:0] mg = 2'b00;
    int mlast = 1;
    bit rec = 0;
    logic [1:0] gseq[$];
    logic [1:0] pg = 2'b00;
    int idle_n = 0;

    initial begin
        wb_clk = 0;
        forever #5 wb_clk = ~wb_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic drive(input int m, input logic cyc, input logic stb, input logic we, input logic [31:0] a);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = a; m0_wdat = ~a; m0_sel = 4'hF;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = a; m1_wdat = ~a; m1_sel = 4'h3;
        end
    endtask

    task automatic run_cyc(input int m, input int nb, input logic we, input logic [31:0] adr0);
        logic [31:0] a;
        logic ack;
        int k;
        @(posedge wb_clk); #1;
        for (int b = 0; b < nb; b++) begin
            a = adr0 != 0 ? adr0 : 32'h3000_0000 | ($urandom & 32'h000F_FFFC);
            drive(m, 1'b1, 1'b1, we, a);
            if (m == 0) q0.push_back('{!we, slv_data(a)});
            else q1.push_back('{!we, slv_data(a)});
            k = 0;
            ack = 0;
            while (!ack && k < 60) begin
                @(negedge wb_clk);
                ack = m == 0 ? m0_ack : m1_ack;
                k++;
            end
            if (!ack) chk("ack_wait", ack, 1);
            @(posedge wb_clk); #1;
        end
        drive(m, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // slave: registered ack after a wait, never acks the 0x3010_xxxx hole
    initial begin
        s_ack = 0;
        s_rdat = 0;
        forever begin
            @(posedge wb_clk); #2;
            if (s_ack) s_ack = 0;
            else if (s_cyc && s_stb && s_adr[31:16] != 16'h3010) begin
                if (wcnt <= 0) begin
                    s_ack = 1;
                    s_rdat = slv_data(s_adr);
                    wcnt = fix_dly >= 0 ? fix_dly : int'($urandom_range(0, 2));
                end else wcnt--;
            end
        end
    end

    always @(negedge wb_clk) begin : monitor
        logic e_scyc;
        logic [1:0] req;
        exp_t e;
        int own, pick;
        e_scyc = !wb_rst && (mg == 2'b01 ? m0_cyc : mg == 2'b10 ? m1_cyc : 1'b0);
        chk("gnt", gnt, mg);
        chk("s_cyc", s_cyc, e_scyc);
        if (e_scyc) begin
            chk("s_adr", s_adr, mg == 2'b01 ? m0_adr : m1_adr);
            chk("s_wdat", s_wdat, mg == 2'b01 ? m0_wdat : m1_wdat);
            chk("s_we", s_we, mg == 2'b01 ? m0_we : m1_we);
        end
        if (mg != 2'b01 || wb_rst) chk("m0_rdat_ungranted", m0_rdat, 0);
        if (mg != 2'b10 || wb_rst) chk("m1_rdat_ungranted", m1_rdat, 0);
        if (m0_ack) begin
            acks0++;
            if (q0.size() == 0) chk("m0_ack_unexpected", m0_ack, 0);
            else begin
                e = q0.pop_front();
                if (e.rd) chk("m0_rdat", m0_rdat, e.dat);
            end
        end
        if (m1_ack) begin
            acks1++;
            if (q1.size() == 0) chk("m1_ack_unexpected", m1_ack, 0);
            else begin
                e = q1.pop_front();
                if (e.rd) chk("m1_rdat", m1_rdat, e.dat);
            end
        end
        if (rec) begin
            if (gnt != 2'b00 && gnt != pg) gseq.push_back(gnt);
            if (gnt == 2'b00 && gseq.size() > 0) idle_n++;
            pg = gnt;
        end
        // grant rules: holder keeps the bus until cyc drops; a free bus goes to the
        // sole requester, or on a tie to the master not served most recently
        if (wb_rst) begin
            mg = 2'b00;
            mlast = 1;
        end else begin
            own = mg == 2'b01 ? 0 : mg == 2'b10 ? 1 : -1;
            if (own < 0 || (own == 0 ? !m0_cyc : !m1_cyc)) begin
                req = {m1_cyc, m0_cyc};
                pick = req == 2'b11 ? 1 - mlast : req == 2'b01 ? 0 : req == 2'b10 ? 1 : -1;
                mg = pick < 0 ? 2'b00 : pick == 0 ? 2'b01 : 2'b10;
                if (pick >= 0) mlast = pick;
            end
        end
    end

    initial begin
        int a0, a1, k, n;
        wb_rst = 1;
        err_clr = 0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge wb_clk);
        #1 wb_rst = 0;
        @(negedge wb_clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_scyc", s_cyc, 0);
        chk("rst_to_err", to_err, 0);

        // reset in the middle of an m0 read
        @(posedge wb_clk); #1 drive(0, 1'b1, 1'b1, 1'b0, 32'h3010_0000);
        repeat (3) @(negedge wb_clk);
        chk("mid_gnt", gnt, 2'b01);
        a0 = acks0;
        @(posedge wb_clk); #1 wb_rst = 1;
        @(negedge wb_clk);
        chk("rst_mid_scyc", s_cyc, 0);
        chk("rst_mid_ack", m0_ack, 0);
        @(posedge wb_clk); #1 wb_rst = 0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge wb_clk);
        chk("rst_mid_gnt", gnt, 0);
        chk("rst_mid_acks", acks0 - a0, 0);

        // tie right after reset: m0 first, then m1 with no idle cycle
        fork
            run_cyc(0, 1, 1'b0, 32'h3000_1000);
            run_cyc(1, 1, 1'b1, 32'h3000_2000);
            begin
                @(posedge wb_clk);
                @(negedge wb_clk);
                @(negedge wb_clk);
                chk("tie_first", gnt, 2'b01);
                k = 0;
                while (gnt == 2'b01 && k < 40) begin
                    @(negedge wb_clk);
                    k++;
                end
                chk("tie_second", gnt, 2'b10);
            end
        join

        // single master write with a 2-cycle slave
        repeat (2) @(posedge wb_clk);
        fix_dly = 2;
        wcnt = 2;
        a0 = acks0;
        a1 = acks1;
        fork
            run_cyc(1, 1, 1'b1, 32'h3001_0000);
            begin
                @(posedge wb_clk);
                @(negedge wb_clk);
                chk("lat_before", s_cyc, 0);
                @(negedge wb_clk);
                chk("lat_after", s_cyc, 1);
            end
        join
        chk("single_m1_acks", acks1 - a1, 1);
        chk("single_m0_acks", acks0 - a0, 0);
        fix_dly = -1;

        // fairness with continuous one-beat requests
        repeat (2) @(posedge wb_clk);
        gseq.delete();
        pg = 2'b00;
        idle_n = 0;
        rec = 1;
        fork
            repeat (4) run_cyc(0, 1, 1'b0, 32'h0);
            repeat (4) run_cyc(1, 1, 1'b1, 32'h0);
        join
        rec = 0;
        chk("fair_len", gseq.size(), 8);
        for (int i = 1; i < gseq.size(); i++) chk("fair_alt", gseq[i], gseq[i-1] ^ 2'b11);
        chk("fair_idle", idle_n, 0);

        // random traffic from both masters
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge wb_clk);
                run_cyc(0, $urandom_range(1, 3), 1'($urandom_range(0, 1)), 32'h0);
            end
            for (int j = 0; j < 25; j++) begin
                repeat ($urandom_range(0, 3)) @(posedge wb_clk);
                run_cyc(1, $urandom_range(1, 3), 1'($urandom_range(0, 1)), 32'h0);
            end
        join
        repeat (3) @(negedge wb_clk);
        chk("to_err_clean", to_err, 0);

        // read of an unmapped address
        @(posedge wb_clk); #1;
        a0 = acks0;
`ifdef WB_ARB_TIMEOUT_EN
        q0.push_back('{1'b1, 32'hDEAD_BEEF});
        drive(0, 1'b1, 1'b1, 1'b0, 32'h3010_0000);
        n = 0;
        k = 0;
        while (k < 40) begin
            @(negedge wb_clk);
            if (m0_ack) break;
            if (s_stb) n++;
            k++;
        end
        chk("to_ack_seen", m0_ack, 1);
        chk("to_stb_cycles", n, 8);
        @(posedge wb_clk); #1 drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge wb_clk);
        chk("to_err_set", to_err, 1);
        @(posedge wb_clk); #1 err_clr = 1;
        @(posedge wb_clk); #1 err_clr = 0;
        @(negedge wb_clk);
        chk("to_err_clr", to_err, 0);
        chk("to_acks", acks0 - a0, 1);
`else
        drive(0, 1'b1, 1'b1, 1'b0, 32'h3010_0000);
        repeat (20) @(negedge wb_clk);
        chk("noto_acks", acks0 - a0, 0);
        chk("noto_to_err", to_err, 0);
        chk("noto_gnt", gnt, 2'b01);
        @(posedge wb_clk); #1 err_clr = 1;
        @(posedge wb_clk); #1 err_clr = 0;
        @(negedge wb_clk);
        chk("noto_to_err_clr", to_err, 0);
        @(posedge wb_clk); #1 drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
`endif
        repeat (3) @(negedge wb_clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
